// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transmit scheduler.
package spi_pkg;

  // Main sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WORD   = 2'd1,
    SAMPLE = 2'd2,
    META   = 2'd3
  } state_t;

  // Highest-priority pending query, as seen by the sequencer in IDLE.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ID   = 2'd1,
    GNT_DIN  = 2'd2,
    GNT_META = 2'd3
  } grant_t;

  localparam logic [31:0] ID_WORD_DEFAULT = 32'h534C4131;  // "1ALS", LSB first
  localparam logic [7:0]  META_TERM       = 8'h00;         // ends a metadata stream

  // Byte i of a word, byte 0 = [7:0].
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/spi_tx_req_latch.sv
// Pending-query flags, dataIn snapshot and fixed-priority grant.
module spi_tx_req_latch
  import spi_pkg::*;
(
  input  logic        clock,
  input  logic        extReset,
  input  logic        cs,
  input  logic        query_id,
  input  logic        query_dataIn,
  input  logic        query_metadata,
  input  logic [31:0] dataIn,
  input  logic        i_take,
  output grant_t      o_grant,
  output logic [31:0] o_snapshot,
  output logic        o_pending
);

  logic        r_pend_id;
  logic        r_pend_din;
  logic        r_pend_meta;
  logic [31:0] r_snapshot;

  logic w_clr_id;
  logic w_clr_din;
  logic w_clr_meta;

  assign w_clr_id   = i_take && (o_grant == GNT_ID);
  assign w_clr_din  = i_take && (o_grant == GNT_DIN);
  assign w_clr_meta = i_take && (o_grant == GNT_META);

  // Flags set by pulses, cleared when their sequence starts; cs high drops all.
  always_ff @(posedge clock or negedge extReset) begin
    if (!extReset) begin
      r_pend_id   <= 1'b0;
      r_pend_din  <= 1'b0;
      r_pend_meta <= 1'b0;
    end else if (cs) begin
      r_pend_id   <= 1'b0;
      r_pend_din  <= 1'b0;
      r_pend_meta <= 1'b0;
    end else begin
      r_pend_id   <= (r_pend_id   && !w_clr_id)   || query_id;
      r_pend_din  <= (r_pend_din  && !w_clr_din)  || query_dataIn;
      r_pend_meta <= (r_pend_meta && !w_clr_meta) || query_metadata;
    end
  end

  // dataIn is frozen at the moment of the query, not when it is served.
  always_ff @(posedge clock or negedge extReset) begin
    if (!extReset) begin
      r_snapshot <= 32'h0;
    end else if (query_dataIn) begin
      r_snapshot <= dataIn;
    end
  end

  // Fixed priority: ID > dataIn > metadata.
  always_comb begin
    o_grant = GNT_NONE;
    if (r_pend_id)        o_grant = GNT_ID;
    else if (r_pend_din)  o_grant = GNT_DIN;
    else if (r_pend_meta) o_grant = GNT_META;
  end

  assign o_snapshot = r_snapshot;
  assign o_pending  = r_pend_id || r_pend_din || r_pend_meta;

endmodule

// File: rtl/spi_tx_scheduler.sv
// Arbitrates ID, dataIn snapshot, metadata and sample bytes onto the MISO byte path.
module spi_tx_scheduler
  import spi_pkg::*;
#(
  parameter logic [31:0] ID_WORD = ID_WORD_DEFAULT
) (
  input  logic        clock,
  input  logic        extReset,
  input  logic        cs,
  input  logic        query_id,
  input  logic        query_dataIn,
  input  logic        query_metadata,
  input  logic [31:0] dataIn,
  input  logic        send,
  input  logic [31:0] send_data,
  input  logic [3:0]  send_valid,
  output logic        send_ready,
  input  logic [7:0]  meta_byte,
  input  logic        meta_valid,
  output logic        meta_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  state_t      r_state,    w_state_next;
  logic [1:0]  r_idx,      w_idx_next;
  logic [31:0] r_word,     w_word_next;
  logic [3:0]  r_bvalid,   w_bvalid_next;
  logic [7:0]  r_tx_byte,  w_tx_byte_next;
  logic        r_tx_valid, w_tx_valid_next;

  grant_t      w_grant;
  logic [31:0] w_snapshot;
  logic        w_pending;
  logic        w_take;
  logic        w_load;
  logic [31:0] w_load_word;
  logic [3:0]  w_load_valid;
  state_t      w_load_state;
  logic [1:0]  w_idx_inc;
  logic        w_tx_fire;
  logic        w_in_meta;

  spi_tx_req_latch u_req (
    .clock          (clock),
    .extReset       (extReset),
    .cs             (cs),
    .query_id       (query_id),
    .query_dataIn   (query_dataIn),
    .query_metadata (query_metadata),
    .dataIn         (dataIn),
    .i_take         (w_take),
    .o_grant        (w_grant),
    .o_snapshot     (w_snapshot),
    .o_pending      (w_pending)
  );

  // Metadata bytes stream straight through; word bytes come from the output register.
  assign w_in_meta  = (r_state == META);
  assign tx_byte    = w_in_meta ? meta_byte  : r_tx_byte;
  assign tx_valid   = w_in_meta ? meta_valid : r_tx_valid;
  assign meta_ready = w_in_meta && tx_ready && meta_valid;
  assign w_tx_fire  = tx_valid && tx_ready;
  assign w_idx_inc  = r_idx + 2'd1;
  assign send_ready = (r_state == IDLE) && !w_pending && !cs;
  assign busy       = (r_state != IDLE) || w_pending;

  // State and output registers.
  always_ff @(posedge clock or negedge extReset) begin
    if (!extReset) begin
      r_state    <= IDLE;
      r_idx      <= 2'd0;
      r_word     <= 32'h0;
      r_bvalid   <= 4'h0;
      r_tx_byte  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_word     <= w_word_next;
      r_bvalid   <= w_bvalid_next;
      r_tx_byte  <= w_tx_byte_next;
      r_tx_valid <= w_tx_valid_next;
    end
  end

  // Arbitration, byte stepping and abort.
  always_comb begin
    w_state_next    = r_state;
    w_idx_next      = r_idx;
    w_word_next     = r_word;
    w_bvalid_next   = r_bvalid;
    w_tx_byte_next  = r_tx_byte;
    w_tx_valid_next = r_tx_valid;
    w_take          = 1'b0;
    w_load          = 1'b0;
    w_load_word     = r_word;
    w_load_valid    = 4'hF;
    w_load_state    = WORD;

    case (r_state)
      IDLE: begin
        if (!cs) begin
          case (w_grant)
            GNT_ID: begin
              w_take      = 1'b1;
              w_load      = 1'b1;
              w_load_word = ID_WORD;
            end
            GNT_DIN: begin
              w_take      = 1'b1;
              w_load      = 1'b1;
              w_load_word = w_snapshot;
            end
            GNT_META: begin
              w_take          = 1'b1;
              w_state_next    = META;
              w_tx_valid_next = 1'b0;
            end
            default: begin
              if (send && send_ready) begin
                w_load       = 1'b1;
                w_load_word  = send_data;
                w_load_valid = send_valid;
                w_load_state = SAMPLE;
              end
            end
          endcase
        end
      end
      WORD, SAMPLE: begin
        // A shown byte advances on transfer; a disabled byte advances after one cycle.
        if (w_tx_fire || !r_tx_valid) begin
          if (r_idx == 2'd3) begin
            w_state_next    = IDLE;
            w_tx_valid_next = 1'b0;
          end else begin
            w_idx_next      = w_idx_inc;
            w_tx_byte_next  = pick_byte(r_word, w_idx_inc);
            w_tx_valid_next = r_bvalid[w_idx_inc];
          end
        end
      end
      META: begin
        if (w_tx_fire && (meta_byte == META_TERM)) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase

    // Starting a word: byte 0 is presented on the very next cycle.
    if (w_load) begin
      w_state_next    = w_load_state;
      w_idx_next      = 2'd0;
      w_word_next     = w_load_word;
      w_bvalid_next   = w_load_valid;
      w_tx_byte_next  = w_load_word[7:0];
      w_tx_valid_next = w_load_valid[0];
    end

    if (cs) begin
      w_state_next    = IDLE;
      w_tx_valid_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Bench for spi_tx_scheduler: directed scenarios plus randomized single requests
// checked against a byte-list reference model.
module tb_spi_tx_scheduler;

  logic        clock = 1'b0;
  logic        extReset = 1'b0;
  logic        cs = 1'b0;
  logic        query_id = 1'b0;
  logic        query_dataIn = 1'b0;
  logic        query_metadata = 1'b0;
  logic [31:0] dataIn = 32'h0;
  logic        send = 1'b0;
  logic [31:0] send_data = 32'h0;
  logic [3:0]  send_valid = 4'h0;
  logic        send_ready;
  logic [7:0]  meta_byte = 8'h00;
  logic        meta_valid = 1'b0;
  logic        meta_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;

  localparam logic [31:0] ID_W = 32'h534C4131;

  always #5 clock = ~clock;

  spi_tx_scheduler dut (
    .clock          (clock),
    .extReset       (extReset),
    .cs             (cs),
    .query_id       (query_id),
    .query_dataIn   (query_dataIn),
    .query_metadata (query_metadata),
    .dataIn         (dataIn),
    .send           (send),
    .send_data      (send_data),
    .send_valid     (send_valid),
    .send_ready     (send_ready),
    .meta_byte      (meta_byte),
    .meta_valid     (meta_valid),
    .meta_ready     (meta_ready),
    .tx_byte        (tx_byte),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .busy           (busy)
  );

  int         n_total = 0;
  int         n_bad = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] meta_q[$];
  int         rdy_mode = 0;  // 0 hold, 1 toggle, 2 random
  int         xfer_cnt = 0;
  int         mready_cnt = 0;
  int         misalign_cnt = 0;
  int         sready_cnt = 0;
  logic       win = 1'b0;
  logic       meta_pop = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Observe on the falling edge; inputs only change just after the rising edge.
  always @(negedge clock) begin
    meta_pop = 1'b0;
    if (extReset) begin
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_byte);
        xfer_cnt++;
      end
      if (meta_ready) begin
        mready_cnt++;
        meta_pop = 1'b1;
        if (!(tx_valid && tx_ready)) misalign_cnt++;
      end
      if (win && busy && send_ready) sready_cnt++;
    end
  end

  // One clock step; updates the metadata generator and tx_ready pattern.
  task automatic tick();
    @(posedge clock);
    #1;
    if (meta_pop && meta_q.size() > 0) void'(meta_q.pop_front());
    meta_valid = (meta_q.size() > 0);
    meta_byte  = (meta_q.size() > 0) ? meta_q[0] : 8'h00;
    if (rdy_mode == 1) tx_ready = ~tx_ready;
    else if (rdy_mode == 2) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    if (busy) check_val("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic push_word(input logic [31:0] w, input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) exp_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic compare_q(input string tag);
    int n;
    check_val({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_val($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    $display("txn %s: %0d bytes", tag, got_q.size());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_id();
    query_id = 1'b1; tick(); query_id = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [3:0]  v;
    int          kind;
    int          len;

    // Reset state
    repeat (3) tick();
    check_val("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_val("rst_tx_byte", 32'(tx_byte), 32'h00);
    check_val("rst_meta_ready", 32'(meta_ready), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_send_ready", 32'(send_ready), 32'd1);
    extReset = 1'b1;
    tick();

    // ID query with exact latency
    pulse_id();
    check_val("id_lat_valid0", 32'(tx_valid), 32'd0);
    check_val("id_busy_pend", 32'(busy), 32'd1);
    tick();
    check_val("id_lat_valid1", 32'(tx_valid), 32'd1);
    check_val("id_first_byte", 32'(tx_byte), 32'h31);
    repeat (4) tick();
    check_val("id_done_busy", 32'(busy), 32'd0);
    check_val("id_done_valid", 32'(tx_valid), 32'd0);
    push_word(ID_W, 4'hF);
    compare_q("id");

    // dataIn snapshot taken at the pulse
    dataIn = 32'hDEADBEEF;
    query_dataIn = 1'b1; tick(); query_dataIn = 1'b0;
    dataIn = 32'h0;
    wait_idle();
    push_word(32'hDEADBEEF, 4'hF);
    compare_q("din");

    // Sample with sparse byte enables
    send = 1'b1; send_data = 32'h44332211; send_valid = 4'b1010;
    tick();
    send = 1'b0;
    check_val("smp_skip0", 32'(tx_valid), 32'd0);
    tick();
    check_val("smp_b1_valid", 32'(tx_valid), 32'd1);
    check_val("smp_b1_byte", 32'(tx_byte), 32'h22);
    tick();
    check_val("smp_skip2", 32'(tx_valid), 32'd0);
    tick();
    check_val("smp_b3_byte", 32'(tx_byte), 32'h44);
    tick();
    check_val("smp_done_busy", 32'(busy), 32'd0);
    push_word(32'h44332211, 4'b1010);
    compare_q("sample_sparse");

    // Queries arriving mid-sample wait; ID beats dataIn
    w = $urandom();
    send = 1'b1; send_data = w; send_valid = 4'hF;
    tick();
    send = 1'b0;
    win = 1'b1;
    tick();
    dataIn = $urandom();
    push_word(w, 4'hF);
    push_word(ID_W, 4'hF);
    push_word(dataIn, 4'hF);
    query_id = 1'b1; query_dataIn = 1'b1; tick();
    query_id = 1'b0; query_dataIn = 1'b0;
    wait_idle();
    win = 1'b0;
    check_val("mid_send_ready", 32'(sready_cnt), 32'd0);
    compare_q("mid_queries");

    // Metadata stream with tx_ready toggling
    meta_q = '{8'h01, 8'h41, 8'h00, 8'h77};
    xfer_cnt = 0; mready_cnt = 0; misalign_cnt = 0;
    rdy_mode = 1;
    query_metadata = 1'b1; tick(); query_metadata = 1'b0;
    wait_idle();
    rdy_mode = 0; tx_ready = 1'b1;
    check_val("meta_xfers", 32'(xfer_cnt), 32'd3);
    check_val("meta_ready_cnt", 32'(mready_cnt), 32'd3);
    check_val("meta_align", 32'(misalign_cnt), 32'd0);
    check_val("meta_left", 32'(meta_q.size()), 32'd1);
    exp_q = '{8'h01, 8'h41, 8'h00};
    compare_q("meta");
    meta_q.delete();
    tick();

    // Abort during WORD idx 2 with metadata pending
    meta_q = '{8'h55, 8'h00};
    pulse_id();
    query_metadata = 1'b1; tick(); query_metadata = 1'b0;
    tick(); tick();
    check_val("abort_at_idx2", 32'(tx_byte), 32'h4C);
    cs = 1'b1; tx_ready = 1'b0;
    tick();
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_tx_valid", 32'(tx_valid), 32'd0);
    cs = 1'b0; tx_ready = 1'b1;
    xfer_cnt = 0;
    repeat (20) tick();
    check_val("abort_no_meta", 32'(xfer_cnt), 32'd0);
    check_val("abort_idle", 32'(busy), 32'd0);
    exp_q = '{8'h31, 8'h41};
    compare_q("abort");
    meta_q.delete();
    tick();

    // Randomized single requests with random back-pressure
    rdy_mode = 2;
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          push_word(ID_W, 4'hF);
          pulse_id();
        end
        1: begin
          w = $urandom();
          dataIn = w;
          push_word(w, 4'hF);
          query_dataIn = 1'b1; tick(); query_dataIn = 1'b0;
          dataIn = $urandom();
        end
        2: begin
          len = $urandom_range(0, 3);
          for (int i = 0; i < len; i++) begin
            w[7:0] = 8'($urandom_range(1, 255));
            meta_q.push_back(w[7:0]);
            exp_q.push_back(w[7:0]);
          end
          meta_q.push_back(8'h00);
          exp_q.push_back(8'h00);
          query_metadata = 1'b1; tick(); query_metadata = 1'b0;
        end
        default: begin
          w = $urandom();
          v = 4'($urandom_range(0, 15));
          push_word(w, v);
          send = 1'b1; send_data = w; send_valid = v;
          tick();
          send = 1'b0;
        end
      endcase
      wait_idle();
      compare_q($sformatf("rnd%0d_k%0d", t, kind));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_tx_scheduler.md
# spi_tx_scheduler

Sequences and arbitrates every byte the SPI slave returns to the host over MISO. It sits between the command side (query pulses and sample readback) and the byte-wide SPI shift-out stage. It owns the single transmit path and shares it between four requesters: ID query, dataIn snapshot query, metadata stream and captured-sample words. Requests are latched, served in fixed priority, and never preempt a sequence already in flight.

## Interface
Parameters:
- ID_WORD, 32'h534C4131, ID response, sent LSB byte first ("1ALS").

Ports:
- clock  in  1  system clock; all logic on rising edge.
- extReset  in  1  asynchronous, active-low reset.
- cs  in  1  chip select, already synchronized, active-low; high = abort.
- query_id  in  1  one-cycle pulse: send ID_WORD.
- query_dataIn  in  1  one-cycle pulse: snapshot dataIn, send 4 bytes.
- query_metadata  in  1  one-cycle pulse: stream metadata until a 0x00 byte has been sent.
- dataIn  in  32  live input probe word.
- send  in  1  sample word request; accepted only when send_ready=1.
- send_data  in  32  sample word, byte 0 = [7:0].
- send_valid  in  4  per-byte enable for send_data.
- send_ready  out  1  scheduler accepts a sample word this cycle.
- meta_byte  in  8  metadata byte from the metadata generator.
- meta_valid  in  1  meta_byte valid.
- meta_ready  out  1  meta_byte consumed this cycle.
- tx_byte  out  8  byte to shifter.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  shifter can accept a byte.
- busy  out  1  any sequence active or any request pending.

## Operation
- Pending flags: pend_id, pend_din, pend_meta are set by their pulses and cleared when that sequence starts. A repeated pulse while pending merges into the existing flag.
- dataIn is captured into a 32-bit snapshot at the cycle query_dataIn is sampled. It is not captured at service time. A second pulse while pend_din is set re-captures.
- Sample accept: send && send_ready. send_data and send_valid are latched, then the scheduler enters SAMPLE.
- send_ready = (state==IDLE) && !pend_id && !pend_din && !pend_meta && !cs.
- Priority from IDLE: pend_id > pend_din > pend_meta > sample. Queries always win over a same-cycle send. That send is not accepted.
- States:
  - IDLE
  - WORD: 4 bytes from the ID word or the snapshot, using idx 0..3.
  - SAMPLE: idx 0..3. A byte whose send_valid bit is 0 takes one cycle with tx_valid=0.
  - META: tx_byte=meta_byte and tx_valid=meta_valid; meta_ready=tx_ready && meta_valid.
- Transfer occurs when tx_valid && tx_ready are high on the same edge.
- idx advances on a transfer or a skip. The state leaves after idx 3, or in META after a 0x00 byte transfers, and returns to IDLE.
- A sample word with send_valid=4'b0000 spends 4 cycles in SAMPLE and sends no bytes.
- Abort: cs high in any state does three things on the next edge:
  - state goes to IDLE;
  - all pending flags clear;
  - tx_valid deasserts.

  A byte already transferred is not recalled.
- busy = (state!=IDLE) || any pending flag.

## Timing
- Reset values: tx_valid 0, tx_byte 8'h00, meta_ready 0, busy 0, send_ready 1 (when cs low), all pending flags 0, state IDLE.
- Query pulse at edge N sets its pending flag after N. If idle, the state enters WORD/META at N+1, and tx_valid is high in the cycle after N+1.
- Sample accepted at edge N: tx_valid for byte 0 is high in the cycle after N.
- With tx_ready held at 1, a full word takes 4 consecutive transfer cycles. The cycle after the last transfer shows busy = 0, provided nothing is pending.
- tx_byte and tx_valid are registered and hold stable while tx_valid && !tx_ready.
- A query pulse arriving mid-sequence waits. The sequence completes, then one IDLE cycle follows before arbitration.

## Structure
- Shared package spi_pkg holds:
  - the state enum: IDLE, WORD, SAMPLE, META;
  - ID_WORD default;
  - the META terminator constant 8'h00.
- One natural sub-module is spi_tx_req_latch. It holds the three pending flags, the dataIn snapshot register and the priority encoder, and it returns the grant to the main FSM.

## Test plan
- query_id pulse, tx_ready=1 -> bytes 0x31,0x41,0x4C,0x53 on 4 consecutive transfers; busy=0 afterwards.
- dataIn=32'hDEADBEEF at pulse, dataIn changed to 0 next cycle -> bytes EF,BE,AD,DE.
- send with data 32'h44332211, valid 4'b1010 -> only 0x22,0x44 sent; one idle tx_valid cycle before each.
- SAMPLE in progress at idx 1, query_id and query_dataIn pulsed in the same cycle -> sample word finishes, then ID bytes, then dataIn bytes; send_ready stays 0 throughout.
- query_metadata with generator supplying 0x01,0x41,0x00 and tx_ready toggling every cycle -> exactly 3 transfers, meta_ready pulses align with transfers, then IDLE.
- cs driven high at WORD idx 2 with pend_meta set -> next cycle IDLE, tx_valid=0, busy=0; no metadata is sent afterwards.
